// File: rtl/universal_shift_reg_if.sv
// ============================================================================
// Module   : universal_shift_reg_if
// Brief    : Control, serial and parallel data bundle for universal_shift_reg.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface universal_shift_reg_if #(
    parameter int N = 5,
    parameter int W = 1
);
    localparam int CNT_W = $clog2(N);

    logic             en;
    logic [2:0]       mode;
    logic [W-1:0]     si_r;
    logic [W-1:0]     si_l;
    logic [N*W-1:0]   pi;
    logic [W-1:0]     so_r;
    logic [W-1:0]     so_l;
    logic [N*W-1:0]   po;
    logic [CNT_W-1:0] shift_cnt;
    logic             frame_done;

    modport master (
        output en, mode, si_r, si_l, pi,
        input  so_r, so_l, po, shift_cnt, frame_done
    );

    modport slave (
        input  en, mode, si_r, si_l, pi,
        output so_r, so_l, po, shift_cnt, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/universal_shift_reg.sv
// ============================================================================
// Module   : universal_shift_reg
// Brief    : N-stage x W-bit universal shift register with frame counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module universal_shift_reg #(
    parameter int N = 5,
    parameter int W = 1
) (
    input  wire                   clk,
    input  wire                   reset,
    universal_shift_reg_if.slave  sr_bus
);
    localparam int CNT_W = $clog2(N);

    localparam logic [2:0] c_MODE_SHR  = 3'b001;
    localparam logic [2:0] c_MODE_SHL  = 3'b010;
    localparam logic [2:0] c_MODE_ROR  = 3'b011;
    localparam logic [2:0] c_MODE_ROL  = 3'b100;
    localparam logic [2:0] c_MODE_LOAD = 3'b101;
    localparam logic [2:0] c_MODE_CLR  = 3'b110;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(N - 1);

    logic [N-1:0][W-1:0] r_q;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_frame_done;

    logic [N-1:0][W-1:0] w_q_next;
    logic                w_advance;
    logic                w_restart;

    // Stage 0 sits at the LSB end, so "right" moves data toward index 0.
    always_comb begin
        w_q_next  = r_q;
        w_advance = 1'b0;
        w_restart = 1'b0;
        if (sr_bus.en) begin
            case (sr_bus.mode)
                c_MODE_SHR: begin
                    w_q_next  = {sr_bus.si_r, r_q[N-1:1]};
                    w_advance = 1'b1;
                end
                c_MODE_SHL: begin
                    w_q_next  = {r_q[N-2:0], sr_bus.si_l};
                    w_advance = 1'b1;
                end
                c_MODE_ROR: begin
                    w_q_next  = {r_q[0], r_q[N-1:1]};
                    w_advance = 1'b1;
                end
                c_MODE_ROL: begin
                    w_q_next  = {r_q[N-2:0], r_q[N-1]};
                    w_advance = 1'b1;
                end
                c_MODE_LOAD: begin
                    w_q_next  = sr_bus.pi;
                    w_restart = 1'b1;
                end
                c_MODE_CLR: begin
                    w_q_next  = '0;
                    w_restart = 1'b1;
                end
                default: begin
                    w_q_next  = r_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q          <= '0;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_q          <= w_q_next;
            r_frame_done <= 1'b0;
            if (w_restart) begin
                r_cnt <= '0;
            end else if (w_advance) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_cnt        <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign sr_bus.so_r       = r_q[0];
    assign sr_bus.so_l       = r_q[N-1];
    assign sr_bus.po         = r_q;
    assign sr_bus.shift_cnt  = r_cnt;
    assign sr_bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
// ============================================================================
// Module   : tb_universal_shift_reg
// Brief    : Directed vector bench: N=5/W=1 table plus an N=4/W=4 sequence.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_universal_shift_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    universal_shift_reg_if #(.N(5), .W(1)) if_a ();
    universal_shift_reg_if #(.N(4), .W(4)) if_b ();

    universal_shift_reg #(.N(5), .W(1)) u_dut_a (
        .clk    (clk),
        .reset  (rst_a),
        .sr_bus (if_a)
    );

    universal_shift_reg #(.N(4), .W(4)) u_dut_b (
        .clk    (clk),
        .reset  (rst_b),
        .sr_bus (if_b)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] mode;
        logic       sir;
        logic       sil;
        logic [4:0] pi;
        logic [4:0] po;
        logic [2:0] cnt;
        logic       fd;
    } vec_t;

    vec_t vq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic add(input logic rst, input logic en, input logic [2:0] mode,
                       input logic sir, input logic sil, input logic [4:0] pi,
                       input logic [4:0] po, input logic [2:0] cnt, input logic fd);
        vec_t v;
        v.rst = rst; v.en = en; v.mode = mode; v.sir = sir; v.sil = sil;
        v.pi = pi; v.po = po; v.cnt = cnt; v.fd = fd;
        vq.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step_b(input logic rst, input logic en, input logic [2:0] mode,
                          input logic [3:0] sir, input logic [3:0] sil, input logic [15:0] pi);
        rst_b = rst; if_b.en = en; if_b.mode = mode;
        if_b.si_r = sir; if_b.si_l = sil; if_b.pi = pi;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; if_a.en = 1'b0; if_a.mode = 3'b000;
        if_a.si_r = 1'b0; if_a.si_l = 1'b0; if_a.pi = '0;
        rst_b = 1'b1; if_b.en = 1'b0; if_b.mode = 3'b000;
        if_b.si_r = '0; if_b.si_l = '0; if_b.pi = '0;

        // rst en mode sir sil pi | po cnt fd
        // Reset overrides a requested right shift
        add(1, 1, 3'b001, 1, 0, 5'b00000, 5'b00000, 3'd0, 0);
        add(1, 1, 3'b001, 1, 0, 5'b00000, 5'b00000, 3'd0, 0);
        // SISO right shift, one full frame
        add(0, 1, 3'b001, 1, 0, 5'b00000, 5'b10000, 3'd1, 0);
        add(0, 1, 3'b001, 1, 0, 5'b00000, 5'b11000, 3'd2, 0);
        add(0, 1, 3'b001, 1, 0, 5'b00000, 5'b11100, 3'd3, 0);
        add(0, 1, 3'b001, 1, 0, 5'b00000, 5'b11110, 3'd4, 0);
        add(0, 1, 3'b001, 1, 0, 5'b00000, 5'b11111, 3'd0, 1);
        add(0, 1, 3'b000, 0, 0, 5'b00000, 5'b11111, 3'd0, 0);
        // Load then rotate right back to the loaded value
        add(0, 1, 3'b101, 0, 0, 5'b00001, 5'b00001, 3'd0, 0);
        add(0, 1, 3'b011, 0, 0, 5'b00000, 5'b10000, 3'd1, 0);
        add(0, 1, 3'b011, 0, 0, 5'b00000, 5'b01000, 3'd2, 0);
        add(0, 1, 3'b011, 0, 0, 5'b00000, 5'b00100, 3'd3, 0);
        add(0, 1, 3'b011, 0, 0, 5'b00000, 5'b00010, 3'd4, 0);
        add(0, 1, 3'b011, 0, 0, 5'b00000, 5'b00001, 3'd0, 1);
        add(0, 1, 3'b000, 0, 0, 5'b00000, 5'b00001, 3'd0, 0);
        // Mixed directions within one frame, then hold/reserved/clear
        add(0, 1, 3'b101, 0, 0, 5'b10110, 5'b10110, 3'd0, 0);
        add(0, 1, 3'b010, 0, 1, 5'b00000, 5'b01101, 3'd1, 0);
        add(0, 1, 3'b100, 0, 0, 5'b00000, 5'b11010, 3'd2, 0);
        add(0, 1, 3'b001, 0, 0, 5'b00000, 5'b01101, 3'd3, 0);
        add(0, 0, 3'b001, 1, 1, 5'b11111, 5'b01101, 3'd3, 0);
        add(0, 1, 3'b111, 1, 1, 5'b11111, 5'b01101, 3'd3, 0);
        add(0, 1, 3'b110, 1, 1, 5'b11111, 5'b00000, 3'd0, 0);
        // Enable low and reserved mode in mid-frame at cnt=3
        add(0, 1, 3'b001, 1, 0, 5'b00000, 5'b10000, 3'd1, 0);
        add(0, 1, 3'b001, 1, 0, 5'b00000, 5'b11000, 3'd2, 0);
        add(0, 1, 3'b001, 1, 0, 5'b00000, 5'b11100, 3'd3, 0);
        add(0, 0, 3'b001, 1, 0, 5'b00000, 5'b11100, 3'd3, 0);
        add(0, 0, 3'b010, 1, 1, 5'b00000, 5'b11100, 3'd3, 0);
        add(0, 1, 3'b111, 1, 1, 5'b00000, 5'b11100, 3'd3, 0);
        add(0, 1, 3'b000, 1, 1, 5'b00000, 5'b11100, 3'd3, 0);
        add(0, 1, 3'b001, 0, 0, 5'b00000, 5'b01110, 3'd4, 0);
        add(0, 1, 3'b001, 0, 0, 5'b00000, 5'b00111, 3'd0, 1);
        // Frame interrupted by clear
        add(0, 1, 3'b001, 1, 0, 5'b00000, 5'b10011, 3'd1, 0);
        add(0, 1, 3'b001, 1, 0, 5'b00000, 5'b11001, 3'd2, 0);
        add(0, 1, 3'b001, 1, 0, 5'b00000, 5'b11100, 3'd3, 0);
        add(0, 1, 3'b110, 1, 0, 5'b00000, 5'b00000, 3'd0, 0);
        add(0, 1, 3'b001, 1, 0, 5'b00000, 5'b10000, 3'd1, 0);
        add(0, 1, 3'b001, 1, 0, 5'b00000, 5'b11000, 3'd2, 0);
        add(0, 1, 3'b001, 1, 0, 5'b00000, 5'b11100, 3'd3, 0);
        add(0, 1, 3'b001, 1, 0, 5'b00000, 5'b11110, 3'd4, 0);
        add(0, 1, 3'b001, 1, 0, 5'b00000, 5'b11111, 3'd0, 1);
        // Frame interrupted by reset
        add(0, 1, 3'b001, 0, 0, 5'b00000, 5'b01111, 3'd1, 0);
        add(0, 1, 3'b001, 0, 0, 5'b00000, 5'b00111, 3'd2, 0);
        add(0, 1, 3'b001, 0, 0, 5'b00000, 5'b00011, 3'd3, 0);
        add(1, 1, 3'b001, 1, 0, 5'b00000, 5'b00000, 3'd0, 0);
        add(0, 1, 3'b001, 1, 0, 5'b00000, 5'b10000, 3'd1, 0);

        foreach (vq[i]) begin
            rst_a     = vq[i].rst;
            if_a.en   = vq[i].en;
            if_a.mode = vq[i].mode;
            if_a.si_r = vq[i].sir;
            if_a.si_l = vq[i].sil;
            if_a.pi   = vq[i].pi;
            @(posedge clk);
            #1;
            check($sformatf("a%0d_po", i),   32'(if_a.po),         32'(vq[i].po));
            check($sformatf("a%0d_sor", i),  32'(if_a.so_r),       32'(vq[i].po[0]));
            check($sformatf("a%0d_sol", i),  32'(if_a.so_l),       32'(vq[i].po[4]));
            check($sformatf("a%0d_cnt", i),  32'(if_a.shift_cnt),  32'(vq[i].cnt));
            check($sformatf("a%0d_fd", i),   32'(if_a.frame_done), 32'(vq[i].fd));
        end
        rst_a = 1'b0; if_a.en = 1'b0;

        // N=4, W=4: reset, load, two left shifts, then right shift and rotate left
        step_b(1, 1, 3'b010, 4'hF, 4'hF, 16'hFFFF);
        step_b(1, 1, 3'b010, 4'hF, 4'hF, 16'hFFFF);
        check("b_rst_po",  32'(if_b.po),         32'h0);
        check("b_rst_cnt", 32'(if_b.shift_cnt),  32'h0);
        step_b(0, 1, 3'b101, 4'h0, 4'h0, 16'hA5C3);
        check("b_load_po", 32'(if_b.po),         32'hA5C3);
        check("b_load_sor", 32'(if_b.so_r),      32'h3);
        step_b(0, 1, 3'b010, 4'h0, 4'hF, 16'h0000);
        check("b_shl1_po", 32'(if_b.po),         32'h5C3F);
        step_b(0, 1, 3'b010, 4'h0, 4'hF, 16'h0000);
        check("b_shl2_po", 32'(if_b.po),         32'hC3FF);
        check("b_shl2_sol", 32'(if_b.so_l),      32'hC);
        check("b_shl2_sor", 32'(if_b.so_r),      32'hF);
        check("b_shl2_cnt", 32'(if_b.shift_cnt), 32'h2);
        check("b_shl2_fd", 32'(if_b.frame_done), 32'h0);
        step_b(0, 1, 3'b001, 4'h1, 4'h0, 16'h0000);
        check("b_shr_po",  32'(if_b.po),         32'h1C3F);
        check("b_shr_cnt", 32'(if_b.shift_cnt),  32'h3);
        step_b(0, 1, 3'b100, 4'h0, 4'h0, 16'h0000);
        check("b_rol_po",  32'(if_b.po),         32'hC3F1);
        check("b_rol_cnt", 32'(if_b.shift_cnt),  32'h0);
        check("b_rol_fd",  32'(if_b.frame_done), 32'h1);
        step_b(0, 1, 3'b000, 4'h0, 4'h0, 16'h0000);
        check("b_hold_fd", 32'(if_b.frame_done), 32'h0);
        check("b_hold_po", 32'(if_b.po),         32'hC3F1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised N-stage, W-bit-per-stage shift register.
- Supports hold, shift right, shift left, rotate right, rotate left, parallel load and clear, selected per cycle by a mode code.
- Has serial I/O at both ends and full parallel in/out.
- A shift counter flags each completed N-shift frame, for serialisers/deserialisers built on top of it.
- With N=5 and W=1, it covers plain serial-in/serial-out use as a strict superset.

Parameters:
N, 5, number of stages (N >= 2)
W, 1, width of each stage in bits (W >= 1)
CNT_W, $clog2(N), width of shift_cnt (derived localparam, not overridable)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous reset, active-high
en  input  1  operation enable; low = hold regardless of mode
mode  input  3  operation select (see Behaviour)
si_r  input  W  serial in for right shift (enters stage N-1)
si_l  input  W  serial in for left shift (enters stage 0)
pi  input  N*W  parallel load data; stage i = pi[i*W +: W]
so_r  output  W  stage 0 contents (right-shift serial out)
so_l  output  W  stage N-1 contents (left-shift serial out)
po  output  N*W  all stages, same packing as pi
shift_cnt  output  CNT_W  shifts/rotates completed in current frame, 0..N-1
frame_done  output  1  one-cycle pulse after Nth shift/rotate of a frame

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- State is q[0..N-1], each W bits. All outputs come directly from registers; no combinational path from inputs to outputs.
- Reset values, on the rising edge with reset=1: all q = 0, shift_cnt = 0, frame_done = 0. Therefore so_r = so_l = po = 0. Reset overrides en and mode.
- en=0: q and shift_cnt hold; frame_done <= 0.
- en=1, mode decode:
  - 000 hold: q unchanged.
  - 001 shift right: q[N-1] <= si_r; q[i] <= q[i+1] for i < N-1; old q[0] is discarded.
  - 010 shift left: q[0] <= si_l; q[i] <= q[i-1] for i > 0; old q[N-1] is discarded.
  - 011 rotate right: q[N-1] <= q[0]; other stages as shift right.
  - 100 rotate left: q[0] <= q[N-1]; other stages as shift left.
  - 101 parallel load: q[i] <= pi[i*W +: W].
  - 110 clear: all q <= 0.
  - 111 reserved: treated as hold.
- Shift/rotate ops are modes 001-100. Each one with en=1 advances the counter:
  - If shift_cnt == N-1: shift_cnt <= 0 and frame_done <= 1.
  - Otherwise: shift_cnt <= shift_cnt + 1 and frame_done <= 0.
- Load (101) and clear (110): shift_cnt <= 0 and frame_done <= 0, which starts a new frame.
- Hold, reserved code, or en=0: shift_cnt holds and frame_done <= 0.
- frame_done is high for exactly one cycle, the cycle after the edge that completed the frame. Back-to-back frames give a pulse every N shift cycles.
- Latency: the new value appears on so_r/so_l/po one cycle after the edge that samples the inputs. A value entering at si_r reaches so_r after N right-shift ops.
- Direction changes mid-frame are allowed. The counter counts ops regardless of direction.
- Reset mid-frame: the counter and data clear on the same edge, and no frame_done is generated.
- Load in the same cycle as a would-be Nth shift cannot happen, because mode selects exactly one op per cycle.

Test Plan:
1. Reset with N=5, W=1: hold reset=1 for 2 edges with en=1, mode=001, si_r=1 -> po=5'b00000, so_r=0, shift_cnt=0, frame_done=0.
2. SISO right shift: after reset, en=1, mode=001, si_r=1 for 5 cycles -> po goes 10000, 11000, 11100, 11110, 11111. so_r first reads 1 after the 5th edge. frame_done is high in exactly the cycle after the 5th edge, and shift_cnt returns to 0.
3. Load then rotate with N=5, W=1: load pi=5'b00001, then mode=011 for 5 cycles -> po goes 10000, 01000, 00100, 00010, 00001 (back to the loaded value), with frame_done pulsing once.
4. Left shift with W=4, N=4: load pi=16'hA5C3, then mode=010 with si_l=4'hF for 2 cycles -> po=16'hC3FF, so_l=4'hC, shift_cnt=2.
5. en/hold/reserved: mid-frame with shift_cnt=3, apply en=0 for 2 cycles, then en=1 with mode=111 -> q and shift_cnt are unchanged and frame_done stays 0.
6. Interrupted frame: do 3 right shifts, then clear (110), then 4 shifts -> po=0 after the clear, no frame_done pulse, and shift_cnt=4. A 5th shift then produces frame_done. Repeat with reset asserted after 3 shifts -> all state is 0 on the next edge.
